// File: rtl/cache_plru_pkg.sv
// Purpose: shared constants, FSM state encoding and PLRU tree type for the PLRU controller.
// Latency: none; this file holds only types and constants.
// Backpressure: not applicable.
// Ports: none.
package cache_plru_pkg;

  localparam int WAYS     = 8;
  localparam int WAYS_REP = 3;
  localparam int SETS     = 64;
  localparam int SET_BITS = 6;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } plru_state_e;

  // Heap-ordered tree: node 0 is the root, children of node i are 2i+1 and 2i+2.
  typedef logic [WAYS-2:0] plru_t;

endpackage

// File: rtl/cache_plru_tree.sv
// Purpose: tree-PLRU victim walk plus path update for one set.
// Latency: purely combinational.
// Backpressure: none.
// Ports:
//   i_tree               current tree bits of the set
//   i_hit / i_hit_way    hit flag and the way that hit
//   o_way / o_tree       chosen way and the tree rewritten to point away from it
module cache_plru_tree
  import cache_plru_pkg::*;
(
  input  plru_t               i_tree,
  input  logic                i_hit,
  input  logic [WAYS_REP-1:0] i_hit_way,
  output logic [WAYS_REP-1:0] o_way,
  output plru_t               o_tree
);

  logic [WAYS_REP-1:0] w_victim;
  logic [WAYS_REP-1:0] w_walk_node;
  logic [WAYS_REP-1:0] w_way;
  logic [WAYS_REP-1:0] w_upd_node;
  logic [WAYS_REP-1:0] w_path;
  logic                w_dir;

  // Victim walk: each visited bit becomes the next way bit, MSB first.
  // {node, 1} + dir computes 2*node + 1 + dir, i.e. the chosen child.
  always_comb begin
    w_victim    = '0;
    w_walk_node = '0;
    for (int lvl = 0; lvl < WAYS_REP; lvl++) begin
      w_victim    = {w_victim[WAYS_REP-2:0], i_tree[w_walk_node]};
      w_walk_node = {w_walk_node[WAYS_REP-2:0], 1'b1}
                  + {{(WAYS_REP-1){1'b0}}, i_tree[w_walk_node]};
    end
  end

  assign w_way = i_hit ? i_hit_way : w_victim;
  assign o_way = w_way;

  // Path update: every node on the chosen way's path points to the other
  // subtree; nodes off the path keep their value.
  always_comb begin
    o_tree     = i_tree;
    w_upd_node = '0;
    w_path     = w_way;
    w_dir      = 1'b0;
    for (int lvl = 0; lvl < WAYS_REP; lvl++) begin
      w_dir              = w_path[WAYS_REP-1];
      o_tree[w_upd_node] = ~w_dir;
      w_upd_node         = {w_upd_node[WAYS_REP-2:0], 1'b1}
                         + {{(WAYS_REP-1){1'b0}}, w_dir};
      w_path             = {w_path[WAYS_REP-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/cache_plru_ctrl.sv
// Purpose: per-set tree-PLRU state keeper; returns the hit way or a victim way and writes the updated tree back.
// Latency: response is valid one cycle after acceptance; one lookup per cycle while rsp_ready is high.
// Backpressure: req_ready drops while a response is stalled, during a clearing sweep, and on a flush pulse.
// Ports:
//   clk, rst_n                          clock and asynchronous active-low reset
//   req_valid/req_ready/req_set/req_hit/req_hit_way   lookup request
//   rsp_valid/rsp_ready/rsp_way/rsp_hit                lookup response
//   flush (in), busy (out)              start and indicate a clearing sweep
module cache_plru_ctrl
  import cache_plru_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic                req_hit,
  input  logic [WAYS_REP-1:0] req_hit_way,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WAYS_REP-1:0] rsp_way,
  output logic                rsp_hit,
  input  logic                flush,
  output logic                busy
);

  plru_state_e         r_state;
  plru_state_e         w_state_nxt;
  logic [SET_BITS-1:0] r_sweep_idx;
  logic [SET_BITS-1:0] w_sweep_idx_nxt;

  // Not reset: contents become defined only through the sweep.
  plru_t               r_plru [SETS];

  logic                r_rsp_valid;
  logic                r_rsp_hit;
  logic [WAYS_REP-1:0] r_rsp_way;

  plru_t               w_cur_tree;
  plru_t               w_new_tree;
  logic [WAYS_REP-1:0] w_way;
  logic                w_accept;

  assign w_cur_tree = r_plru[req_set];

  cache_plru_tree u_tree (
    .i_tree    (w_cur_tree),
    .i_hit     (req_hit),
    .i_hit_way (req_hit_way),
    .o_way     (w_way),
    .o_tree    (w_new_tree)
  );

  assign req_ready = (r_state == RUN) & ~flush & (~r_rsp_valid | rsp_ready);
  assign w_accept  = req_valid & req_ready;
  assign busy      = (r_state == INIT);
  assign rsp_valid = r_rsp_valid;
  assign rsp_way   = r_rsp_way;
  assign rsp_hit   = r_rsp_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  // flush is only honoured in RUN; a sweep in progress simply runs on.
  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    case (r_state)
      INIT: begin
        w_sweep_idx_nxt = r_sweep_idx + 1'b1;
        if (r_sweep_idx == SET_BITS'(SETS - 1)) begin
          w_state_nxt     = RUN;
          w_sweep_idx_nxt = '0;
        end
      end
      RUN: begin
        if (flush) begin
          w_state_nxt     = INIT;
          w_sweep_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = INIT;
        w_sweep_idx_nxt = '0;
      end
    endcase
  end

  // Write lands at the accepting edge, so a back-to-back request to the same
  // set reads the freshly written tree without any forwarding path.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_plru[r_sweep_idx] <= '0;
    end else if (w_accept) begin
      r_plru[req_set] <= w_new_tree;
    end
  end

  // A response still pending at a flush is kept and drains normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_way   <= '0;
      r_rsp_hit   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_way   <= w_way;
      r_rsp_hit   <= req_hit;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_plru_ctrl.sv
// Purpose: directed bench for cache_plru_ctrl with a response scoreboard.
// Latency: expected entries are queued at request acceptance and retired at response handshake.
// Backpressure: rsp_ready is held low in selected steps to stall the response path.
module tb_cache_plru_ctrl;
  import cache_plru_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic [SET_BITS-1:0] req_set;
  logic                req_hit;
  logic [WAYS_REP-1:0] req_hit_way;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WAYS_REP-1:0] rsp_way;
  logic                rsp_hit;
  logic                flush;
  logic                busy;

  // Expected way for the request currently driven.
  logic [WAYS_REP-1:0] exp_way;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entry: {hit, way}.
  logic [WAYS_REP:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cache_plru_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_set     (req_set),
    .req_hit     (req_hit),
    .req_hit_way (req_hit_way),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_way     (rsp_way),
    .rsp_hit     (rsp_hit),
    .flush       (flush),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Retire at the handshake, enqueue at acceptance; both sampled mid-cycle.
  always @(negedge clk) begin
    logic [WAYS_REP:0] e;
    if (rsp_valid && rsp_ready) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL rsp_unexpected observed way=%0d expected no response", rsp_way);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_way", 32'(rsp_way), 32'(e[WAYS_REP-1:0]));
        check("rsp_hit", 32'(rsp_hit), 32'(e[WAYS_REP]));
      end
    end
    if (req_valid && req_ready) begin
      sb.push_back({req_hit, exp_way});
    end
  end

  // Drive a request and wait (bounded) for its acceptance edge; req_valid stays high.
  task automatic send(input logic [SET_BITS-1:0] s, input logic h,
                      input logic [WAYS_REP-1:0] w, input logic [WAYS_REP-1:0] e);
    int n;
    n           = 0;
    req_valid   = 1'b1;
    req_set     = s;
    req_hit     = h;
    req_hit_way = w;
    exp_way     = e;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // busy=1/req_ready=0 for SETS cycles, then busy=0/req_ready=1.
  task automatic expect_sweep(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      if ({busy, req_ready} !== 2'b10) bad++;
    end
    check({tag, "_busy_cycles"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({tag, "_done"}, 32'({busy, req_ready}), 32'b01);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_set     = '0;
    req_hit     = 1'b0;
    req_hit_way = '0;
    exp_way     = '0;
    rsp_ready   = 1'b1;
    flush       = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy),      32'd1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_way",   32'(rsp_way),   32'd0);
    check("rst_rsp_hit",   32'(rsp_hit),   32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_sweep("init");

    // Repeated misses on set 5 walk the tree.
    send(6'd5, 1'b0, 3'd0, 3'd0);
    send(6'd5, 1'b0, 3'd0, 3'd4);
    send(6'd5, 1'b0, 3'd0, 3'd2);
    send(6'd5, 1'b0, 3'd0, 3'd6);
    idle();

    // Hits steer the next victim; set 10 starts from a clean tree.
    send(6'd9,  1'b1, 3'd4, 3'd4);
    send(6'd9,  1'b0, 3'd0, 3'd0);
    send(6'd9,  1'b0, 3'd0, 3'd6);
    send(6'd10, 1'b1, 3'd0, 3'd0);
    send(6'd10, 1'b0, 3'd0, 3'd4);
    idle();

    // Back-to-back misses visit every way of set 3 once.
    send(6'd3, 1'b0, 3'd0, 3'd0);
    send(6'd3, 1'b0, 3'd0, 3'd4);
    send(6'd3, 1'b0, 3'd0, 3'd2);
    send(6'd3, 1'b0, 3'd0, 3'd6);
    send(6'd3, 1'b0, 3'd0, 3'd1);
    send(6'd3, 1'b0, 3'd0, 3'd5);
    send(6'd3, 1'b0, 3'd0, 3'd3);
    send(6'd3, 1'b0, 3'd0, 3'd7);
    idle();

    // Stalled response blocks new requests and holds its value.
    rsp_ready = 1'b0;
    send(6'd5, 1'b0, 3'd0, 3'd1);
    req_set = 6'd21;
    exp_way = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_way",   32'(rsp_way),   32'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send(6'd21, 1'b0, 3'd0, 3'd0);
    idle();

    // Flush wins over a simultaneous request, then the array is clean.
    req_valid = 1'b1;
    req_set   = 6'd30;
    req_hit   = 1'b0;
    exp_way   = 3'd0;
    flush     = 1'b1;
    @(negedge clk);
    check("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    expect_sweep("flush");
    send(6'd5,  1'b0, 3'd0, 3'd0);
    send(6'd3,  1'b0, 3'd0, 3'd0);
    send(6'd30, 1'b0, 3'd0, 3'd0);
    idle();

    // Pending response survives a flush and drains during the sweep.
    rsp_ready = 1'b0;
    send(6'd40, 1'b0, 3'd0, 3'd0);
    req_valid = 1'b0;
    flush     = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_pending_valid", 32'({busy, rsp_valid}), 32'b11);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-sweep restarts the full sweep.
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy",      32'(busy),      32'd1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_sweep("midrst");
    send(6'd40, 1'b0, 3'd0, 3'd0);
    send(6'd63, 1'b1, 3'd7, 3'd7);
    send(6'd63, 1'b0, 3'd0, 3'd0);
    idle();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
